mano_control_unit: RTL and testbench

Timing-and-control sequencer for the 16-bit Mano basic computer. It holds the sequence counter, the indirect flip-flop I and the run flip-flop S. It decodes IR, flags and the current timing step into the LD/INR/CLR strobes for AR, PC, DR, AC, IR and TR, the common-bus select, memory read/write, ALU op and E control. It sits beside the register file and bus mux and drives one register-transfer step per clock.

---
 rtl/mano_pkg.sv | 43 ++++
 rtl/mano_control_unit_if.sv | 34 +++
 rtl/mano_seq_counter.sv | 24 ++
 rtl/mano_control_unit.sv | 174 +++++++++++++++++
 tb/tb_mano_control_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer control unit:
// bus source codes, ALU operations, opcodes and register-reference bit positions.
package mano_pkg;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_TR   = 3'd6;
    localparam logic [2:0] SEL_MEM  = 3'd7;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_DR   = 3'd2;
    localparam logic [2:0] ALU_CMA  = 3'd3;
    localparam logic [2:0] ALU_CIR  = 3'd4;
    localparam logic [2:0] ALU_CIL  = 3'd5;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_LDA   = 3'd2;
    localparam logic [2:0] OP_STA   = 3'd3;
    localparam logic [2:0] OP_BUN   = 3'd4;
    localparam logic [2:0] OP_BSA   = 3'd5;
    localparam logic [2:0] OP_ISZ   = 3'd6;
    localparam logic [2:0] OP_REG   = 3'd7;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

endpackage

// File: rtl/mano_control_unit_if.sv
// Control/status bundle between the Mano control unit (master) and the
// register file / bus mux datapath (slave).
interface mano_control_unit_if;

    logic [15:0] IR;
    logic        AC15;
    logic        AC_ZERO;
    logic        E;
    logic        DR_ZERO;

    logic [2:0]  BUS_SEL;
    logic        AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR;
    logic        AC_LD, AC_INR, AC_CLR, IR_LD, TR_LD;
    logic        MEM_RD, MEM_WR;
    logic [2:0]  ALU_OP;
    logic        E_LD, E_CLR, E_CMP;
    logic [3:0]  SC;
    logic        HALT;

    modport master (
        input  IR, AC15, AC_ZERO, E, DR_ZERO,
        output BUS_SEL, AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR,
               AC_LD, AC_INR, AC_CLR, IR_LD, TR_LD, MEM_RD, MEM_WR,
               ALU_OP, E_LD, E_CLR, E_CMP, SC, HALT
    );

    modport slave (
        output IR, AC15, AC_ZERO, E, DR_ZERO,
        input  BUS_SEL, AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR,
               AC_LD, AC_INR, AC_CLR, IR_LD, TR_LD, MEM_RD, MEM_WR,
               ALU_OP, E_LD, E_CLR, E_CMP, SC, HALT
    );

endinterface

// File: rtl/mano_seq_counter.sv
// 4-bit timing sequence counter; synchronous clear wins over increment.
module mano_seq_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inr_i,
    output logic [3:0] sc_o
);

    logic [3:0] sc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= 4'd0;
        end else if (clr_i) begin
            sc_q <= 4'd0;
        end else if (inr_i) begin
            sc_q <= sc_q + 4'd1;
        end
    end

    assign sc_o = sc_q;

endmodule

// File: rtl/mano_control_unit.sv
// Timing-and-control sequencer for the Mano basic computer: holds SC, I and S
// and decodes IR, flags and the current step into register-transfer strobes.
module mano_control_unit
    import mano_pkg::*;
(
    input  logic                 CLK,
    input  logic                 NCLR,
    mano_control_unit_if.master  cu
);

    logic [3:0] sc;
    logic       sc_clr, sc_inr;
    logic       i_q, i_d;
    logic       s_q, s_d;
    logic [2:0] d;

    assign d = cu.IR[14:12];

    mano_seq_counter u_sc (
        .clk   (CLK),
        .rst_n (NCLR),
        .clr_i (sc_clr),
        .inr_i (sc_inr),
        .sc_o  (sc)
    );

    always_ff @(posedge CLK or negedge NCLR) begin
        if (!NCLR) begin
            i_q <= 1'b0;
            s_q <= 1'b1;
        end else begin
            i_q <= i_d;
            s_q <= s_d;
        end
    end

    always_comb begin
        cu.BUS_SEL = SEL_NONE;
        cu.ALU_OP  = ALU_AND;
        cu.AR_LD   = 1'b0;
        cu.AR_INR  = 1'b0;
        cu.PC_LD   = 1'b0;
        cu.PC_INR  = 1'b0;
        cu.DR_LD   = 1'b0;
        cu.DR_INR  = 1'b0;
        cu.AC_LD   = 1'b0;
        cu.AC_INR  = 1'b0;
        cu.AC_CLR  = 1'b0;
        cu.IR_LD   = 1'b0;
        cu.TR_LD   = 1'b0;
        cu.MEM_RD  = 1'b0;
        cu.MEM_WR  = 1'b0;
        cu.E_LD    = 1'b0;
        cu.E_CLR   = 1'b0;
        cu.E_CMP   = 1'b0;
        sc_clr     = 1'b0;
        i_d        = i_q;
        s_d        = s_q;

        if (!s_q) begin
            // halted: hold SC at 0 with every strobe idle until reset
            sc_clr = 1'b1;
        end else begin
            case (sc)
                4'd0: begin
                    cu.BUS_SEL = SEL_PC;
                    cu.AR_LD   = 1'b1;
                end
                4'd1: begin
                    cu.BUS_SEL = SEL_MEM;
                    cu.MEM_RD  = 1'b1;
                    cu.IR_LD   = 1'b1;
                    cu.PC_INR  = 1'b1;
                end
                4'd2: begin
                    cu.BUS_SEL = SEL_IR;
                    cu.AR_LD   = 1'b1;
                    i_d        = cu.IR[15];
                end
                4'd3: begin
                    if (d == OP_REG) begin
                        sc_clr = 1'b1;
                        if (!i_q) begin
                            cu.AC_CLR = cu.IR[RR_CLA];
                            cu.E_CLR  = cu.IR[RR_CLE];
                            cu.E_CMP  = cu.IR[RR_CME];
                            cu.AC_INR = cu.IR[RR_INC];
                            cu.AC_LD  = cu.IR[RR_CMA] | cu.IR[RR_CIR] | cu.IR[RR_CIL];
                            cu.E_LD   = cu.IR[RR_CIR] | cu.IR[RR_CIL];
                            if (cu.IR[RR_CMA]) cu.ALU_OP = ALU_CMA;
                            if (cu.IR[RR_CIR]) cu.ALU_OP = ALU_CIR;
                            if (cu.IR[RR_CIL]) cu.ALU_OP = ALU_CIL;
                            cu.PC_INR = (cu.IR[RR_SPA] & ~cu.AC15) |
                                        (cu.IR[RR_SNA] &  cu.AC15) |
                                        (cu.IR[RR_SZA] &  cu.AC_ZERO) |
                                        (cu.IR[RR_SZE] & ~cu.E);
                            if (cu.IR[RR_HLT]) s_d = 1'b0;
                        end
                    end else if (i_q) begin
                        cu.BUS_SEL = SEL_MEM;
                        cu.MEM_RD  = 1'b1;
                        cu.AR_LD   = 1'b1;
                    end
                end
                4'd4: begin
                    case (d)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            cu.BUS_SEL = SEL_MEM;
                            cu.MEM_RD  = 1'b1;
                            cu.DR_LD   = 1'b1;
                        end
                        OP_STA: begin
                            cu.BUS_SEL = SEL_AC;
                            cu.MEM_WR  = 1'b1;
                            sc_clr     = 1'b1;
                        end
                        OP_BUN: begin
                            cu.BUS_SEL = SEL_AR;
                            cu.PC_LD   = 1'b1;
                            sc_clr     = 1'b1;
                        end
                        OP_BSA: begin
                            cu.BUS_SEL = SEL_PC;
                            cu.MEM_WR  = 1'b1;
                            cu.AR_INR  = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                4'd5: begin
                    case (d)
                        OP_AND: begin
                            cu.AC_LD  = 1'b1;
                            cu.ALU_OP = ALU_AND;
                            sc_clr    = 1'b1;
                        end
                        OP_ADD: begin
                            cu.AC_LD  = 1'b1;
                            cu.E_LD   = 1'b1;
                            cu.ALU_OP = ALU_ADD;
                            sc_clr    = 1'b1;
                        end
                        OP_LDA: begin
                            cu.AC_LD  = 1'b1;
                            cu.ALU_OP = ALU_DR;
                            sc_clr    = 1'b1;
                        end
                        OP_BSA: begin
                            cu.BUS_SEL = SEL_AR;
                            cu.PC_LD   = 1'b1;
                            sc_clr     = 1'b1;
                        end
                        OP_ISZ:  cu.DR_INR = 1'b1;
                        default: sc_clr = 1'b1;
                    endcase
                end
                4'd6: begin
                    sc_clr = 1'b1;
                    if (d == OP_ISZ) begin
                        cu.BUS_SEL = SEL_DR;
                        cu.MEM_WR  = 1'b1;
                        cu.PC_INR  = cu.DR_ZERO;
                    end
                end
                default: sc_clr = 1'b1;
            endcase
        end
    end

    assign sc_inr  = s_q & ~sc_clr;
    assign cu.SC   = sc;
    assign cu.HALT = ~s_q;

endmodule

// File: tb/tb_mano_control_unit.sv
// Scoreboarded bench for mano_control_unit: directed instruction sequences push
// hand-computed per-cycle outputs; a negedge monitor pops and compares.
module tb_mano_control_unit;

    logic CLK;
    logic NCLR;

    mano_control_unit_if cu ();

    mano_control_unit dut (
        .CLK  (CLK),
        .NCLR (NCLR),
        .cu   (cu.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam logic [15:0] S_AR_LD  = 16'h8000;
    localparam logic [15:0] S_AR_INR = 16'h4000;
    localparam logic [15:0] S_PC_LD  = 16'h2000;
    localparam logic [15:0] S_PC_INR = 16'h1000;
    localparam logic [15:0] S_DR_LD  = 16'h0800;
    localparam logic [15:0] S_DR_INR = 16'h0400;
    localparam logic [15:0] S_AC_LD  = 16'h0200;
    localparam logic [15:0] S_AC_INR = 16'h0100;
    localparam logic [15:0] S_AC_CLR = 16'h0080;
    localparam logic [15:0] S_IR_LD  = 16'h0040;
    localparam logic [15:0] S_TR_LD  = 16'h0020;
    localparam logic [15:0] S_MEM_RD = 16'h0010;
    localparam logic [15:0] S_MEM_WR = 16'h0008;
    localparam logic [15:0] S_E_LD   = 16'h0004;
    localparam logic [15:0] S_E_CLR  = 16'h0002;
    localparam logic [15:0] S_E_CMP  = 16'h0001;

    int errors = 0;
    int checks = 0;
    int tag    = 0;

    logic [26:0] exp_q  [$];
    logic [26:0] mask_q [$];
    int          tag_q  [$];

    function automatic logic [26:0] mkvec(input logic [3:0] sc, input logic [2:0] bus,
                                          input logic [2:0] alu, input logic [15:0] st,
                                          input logic halt);
        return {sc, halt, bus, alu, st};
    endfunction

    function automatic logic [26:0] actual();
        return {cu.SC, cu.HALT, cu.BUS_SEL, cu.ALU_OP,
                cu.AR_LD, cu.AR_INR, cu.PC_LD, cu.PC_INR, cu.DR_LD, cu.DR_INR,
                cu.AC_LD, cu.AC_INR, cu.AC_CLR, cu.IR_LD, cu.TR_LD,
                cu.MEM_RD, cu.MEM_WR, cu.E_LD, cu.E_CLR, cu.E_CMP};
    endfunction

    task automatic check(input string nm, input int id, input logic [26:0] act,
                         input logic [26:0] exp, input logic [26:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s#%0d got={sc,halt,bus,alu,strobes}=%h required=%h (mask %h)",
                     nm, id, act, exp, mask);
        end
    endtask

    // push one cycle's expectation, then advance to 1ns after the next rising edge
    task automatic cyc(input logic [3:0] sc, input logic [2:0] bus, input logic [2:0] alu,
                       input logic [15:0] st, input logic halt);
        logic [26:0] m;
        m = '1;
        if ((st & (S_AC_LD | S_E_LD)) == 16'h0) m[18:16] = 3'b000;
        exp_q.push_back(mkvec(sc, bus, alu, st, halt));
        mask_q.push_back(m);
        tag_q.push_back(tag);
        tag++;
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch();
        cyc(4'd0, 3'd2, 3'd0, S_AR_LD, 1'b0);
        cyc(4'd1, 3'd7, 3'd0, S_MEM_RD | S_IR_LD | S_PC_INR, 1'b0);
        cyc(4'd2, 3'd5, 3'd0, S_AR_LD, 1'b0);
    endtask

    task automatic set_in(input logic [15:0] ir, input logic ac15, input logic acz,
                          input logic e, input logic drz);
        cu.IR      = ir;
        cu.AC15    = ac15;
        cu.AC_ZERO = acz;
        cu.E       = e;
        cu.DR_ZERO = drz;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            check("step", tag_q.pop_front(), actual(), exp_q.pop_front(), mask_q.pop_front());
        end
    end

    initial begin
        NCLR = 1'b0;
        set_in(16'h2005, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        cyc(4'd0, 3'd2, 3'd0, S_AR_LD, 1'b0);
        NCLR = 1'b1;

        // LDA direct
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        cyc(4'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD, 1'b0);
        cyc(4'd5, 3'd0, 3'd2, S_AC_LD, 1'b0);

        // ADD indirect
        set_in(16'h9010, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd7, 3'd0, S_MEM_RD | S_AR_LD, 1'b0);
        cyc(4'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD, 1'b0);
        cyc(4'd5, 3'd0, 3'd1, S_AC_LD | S_E_LD, 1'b0);

        // ISZ with and without a zero result
        for (int k = 0; k < 2; k++) begin
            set_in(16'h6020, 1'b0, 1'b0, 1'b0, (k == 0));
            fetch();
            cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
            cyc(4'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD, 1'b0);
            cyc(4'd5, 3'd0, 3'd0, S_DR_INR, 1'b0);
            cyc(4'd6, 3'd3, 3'd0, (k == 0) ? (S_MEM_WR | S_PC_INR) : S_MEM_WR, 1'b0);
        end

        set_in(16'h3005, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        cyc(4'd4, 3'd4, 3'd0, S_MEM_WR, 1'b0);

        set_in(16'h4005, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        cyc(4'd4, 3'd1, 3'd0, S_PC_LD, 1'b0);

        set_in(16'h5005, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        cyc(4'd4, 3'd2, 3'd0, S_MEM_WR | S_AR_INR, 1'b0);
        cyc(4'd5, 3'd1, 3'd0, S_PC_LD, 1'b0);

        set_in(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        cyc(4'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD, 1'b0);
        cyc(4'd5, 3'd0, 3'd0, S_AC_LD, 1'b0);

        // I/O word is a 4-cycle no-op
        set_in(16'hF800, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);

        // register-reference combinations
        set_in(16'h7024, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, S_AC_INR | S_PC_INR, 1'b0);

        set_in(16'h7C18, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, S_AC_CLR | S_E_CLR | S_PC_INR, 1'b0);

        set_in(16'h7102, 1'b1, 1'b0, 1'b1, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, S_E_CMP, 1'b0);

        set_in(16'h7080, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd4, S_AC_LD | S_E_LD, 1'b0);

        set_in(16'h7040, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd5, S_AC_LD | S_E_LD, 1'b0);

        // HLT then stay halted
        set_in(16'h7001, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        for (int k = 0; k < 20; k++) cyc(4'd0, 3'd0, 3'd0, 16'h0, 1'b1);

        NCLR = 1'b0;
        cyc(4'd0, 3'd2, 3'd0, S_AR_LD, 1'b0);
        NCLR = 1'b1;

        // ADD aborted by reset at T4
        set_in(16'h1005, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        exp_q.push_back(mkvec(4'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD, 1'b0));
        mask_q.push_back(27'h7F8FFFF);
        tag_q.push_back(tag);
        tag++;
        @(negedge CLK);
        #1;
        NCLR = 1'b0;
        #1;
        check("abort_now", tag, actual(), mkvec(4'd0, 3'd2, 3'd0, S_AR_LD, 1'b0), 27'h7F8FFFF);
        @(posedge CLK);
        #1;
        cyc(4'd0, 3'd2, 3'd0, S_AR_LD, 1'b0);
        NCLR = 1'b1;

        set_in(16'h4005, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch();
        cyc(4'd3, 3'd0, 3'd0, 16'h0, 1'b0);
        cyc(4'd4, 3'd1, 3'd0, S_PC_LD, 1'b0);
        cyc(4'd0, 3'd2, 3'd0, S_AR_LD, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
